// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, drives a single-port RAM
// handshake (strobe/gnt, rvalid) and writes load results back to the register file.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_byte,
  input  logic [31:0] addr,
  input  logic [31:0] str_data,
  input  logic [3:0]  rd_addr,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] w_data_ldr,
  output logic [3:0]  w_addr_ldr,
  output logic        w_en_ldr,
  output logic        stall,
  output logic        align_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t      state, state_nx;
  logic        lat_load, lat_byte;
  logic [1:0]  lat_lane;
  logic [10:0] lat_waddr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [3:0]  lat_rd;
  logic [31:0] ld_data;
  logic [31:0] rdata_sel;
  logic        misaligned, accept, capture;
  logic        addr_unused;

  // Only a 2K-word RAM sits behind this unit; upper address bits are don't-care.
  assign addr_unused = &{1'b0, addr[31:13]};

  assign misaligned = !is_byte && (addr[1:0] != 2'b00);

  always_comb begin
    req_ready = (state == S_IDLE);
    accept    = req_valid && req_ready && !misaligned;
    capture   = ((state == S_REQ) && mem_gnt && lat_load && mem_rvalid) ||
                ((state == S_WAIT) && mem_rvalid);
    mem_rd    = (state == S_REQ) && lat_load;
    mem_wr    = (state == S_REQ) && !lat_load;
    mem_be    = mem_wr ? lat_be : '0;
    mem_addr  = lat_waddr;
    mem_wdata = lat_wdata;
    stall     = (state != S_IDLE) || req_valid;
    w_en_ldr  = (state == S_WB);
    w_addr_ldr = lat_rd;
    w_data_ldr = ld_data;
  end

  always_comb begin
    rdata_sel = mem_rdata;
    if (lat_byte) begin
      case (lat_lane)
        2'd0:    rdata_sel = {24'h0, mem_rdata[7:0]};
        2'd1:    rdata_sel = {24'h0, mem_rdata[15:8]};
        2'd2:    rdata_sel = {24'h0, mem_rdata[23:16]};
        default: rdata_sel = {24'h0, mem_rdata[31:24]};
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_REQ;
      S_REQ: begin
        if (mem_gnt) begin
          if (!lat_load)       state_nx = S_IDLE;
          else if (mem_rvalid) state_nx = S_WB;
          else                 state_nx = S_WAIT;
        end
      end
      S_WAIT: if (mem_rvalid) state_nx = S_WB;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_load  <= 1'b0;
      lat_byte  <= 1'b0;
      lat_lane  <= '0;
      lat_waddr <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_rd    <= '0;
      ld_data   <= '0;
      align_err <= 1'b0;
    end else begin
      state     <= state_nx;
      align_err <= req_valid && req_ready && misaligned;
      if (accept) begin
        lat_load  <= is_load;
        lat_byte  <= is_byte;
        lat_lane  <= addr[1:0];
        lat_waddr <= addr[12:2];
        lat_wdata <= is_byte ? {4{str_data[7:0]}} : str_data;
        lat_be    <= is_byte ? (4'b0001 << addr[1:0]) : 4'b1111;
        lat_rd    <= rd_addr;
      end
      if (capture) ld_data <= rdata_sel;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: task-driven ops with a RAM responder,
// plus a per-cycle compare process against an arithmetic model of each op.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, is_load, is_byte;
  logic [31:0] addr, str_data;
  logic [3:0]  rd_addr;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rd, mem_wr, mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] w_data_ldr;
  logic [3:0]  w_addr_ldr;
  logic        w_en_ldr, stall, align_err;

  int checks = 0;
  int failures = 0;
  int wb_seen = 0;
  int exp_wb = 0;

  // Model of the op currently in flight
  bit          m_active = 1'b0;
  bit          m_load, m_byte;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_rd;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_byte(is_byte), .addr(addr), .str_data(str_data),
    .rd_addr(rd_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr),
    .w_en_ldr(w_en_ldr), .stall(stall), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] f_be(input bit b, input logic [31:0] a);
    int lane = int'(a[1:0]);
    return b ? 4'(1 << lane) : 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input bit b, input logic [31:0] d);
    logic [31:0] by = d & 32'hFF;
    return b ? (by * 32'h01010101) : d;
  endfunction

  function automatic logic [31:0] f_load(input bit b, input logic [31:0] a, input logic [31:0] r);
    int lane = int'(a[1:0]);
    return b ? ((r >> (8 * lane)) & 32'hFF) : r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 0);
        chk("stall_rule", 32'(stall), 32'(req_valid | !req_ready));
        if (mem_rd || mem_wr) begin
          chk("strobe_allowed", 32'(m_active), 1);
          chk("strobe_dir", 32'(mem_rd), 32'(m_load));
          chk("model_mem_addr", 32'(mem_addr), 32'(m_addr[12:2]));
          if (mem_wr) begin
            chk("model_mem_be", 32'(mem_be), 32'(f_be(m_byte, m_addr)));
            chk("model_mem_wdata", mem_wdata, f_wdata(m_byte, m_data));
          end
        end
        if (w_en_ldr) begin
          wb_seen++;
          chk("wb_allowed", 32'(m_active & m_load), 1);
          chk("model_w_addr", 32'(w_addr_ldr), 32'(m_rd));
          chk("model_w_data", w_data_ldr, f_load(m_byte, m_addr, m_rdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input bit ld, input bit bt, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd, input int gd, input int rvd,
                       input logic [31:0] rdat, input logic [31:0] exp_w,
                       input logic [10:0] exp_ma, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_op", 32'(req_ready), 1);
    m_load = ld; m_byte = bt; m_addr = a; m_data = d; m_rd = rd; m_active = 1'b1;
    is_load = ld; is_byte = bt; addr = a; str_data = d; rd_addr = rd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    // Scribble inputs: the unit must work from its latched copy
    is_load = ~ld; is_byte = ~bt; addr = 32'hFFFF_FFFF; str_data = 32'h0; rd_addr = 4'h0;
    for (int i = 0; i < gd; i++) begin
      chk("strobe_held", 32'(ld ? mem_rd : mem_wr), 1);
      @(negedge clk);
    end
    chk("strobe_at_gnt", 32'(ld ? mem_rd : mem_wr), 1);
    chk("mem_addr", 32'(mem_addr), 32'(exp_ma));
    if (!ld) begin
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("mem_wdata", mem_wdata, exp_wd);
    end
    mem_gnt = 1'b1;
    if (ld && rvd == 0) begin
      mem_rvalid = 1'b1; mem_rdata = rdat; m_rdata = rdat;
    end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    if (!ld) begin
      chk("store_done_ready", 32'(req_ready), 1);
      chk("store_done_stall", 32'(stall), 0);
      chk("store_done_wr", 32'(mem_wr), 0);
      m_active = 1'b0;
    end else begin
      if (rvd > 0) begin
        for (int i = 0; i < rvd - 1; i++) begin
          chk("wait_no_wb", 32'(w_en_ldr), 0);
          chk("wait_no_rd", 32'(mem_rd), 0);
          @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rdat; m_rdata = rdat;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      end
      chk("wb_en", 32'(w_en_ldr), 1);
      chk("wb_addr", 32'(w_addr_ldr), 32'(rd));
      chk("wb_data", w_data_ldr, exp_w);
      exp_wb++;
      @(negedge clk);
      chk("wb_one_cycle", 32'(w_en_ldr), 0);
      chk("ready_after_wb", 32'(req_ready), 1);
      m_active = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_byte = 1'b0;
    addr = '0; str_data = '0; rd_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_w_en", 32'(w_en_ldr), 0);
    chk("rst_align_err", 32'(align_err), 0);
    chk("rst_w_data", w_data_ldr, 0);
    chk("rst_w_addr", 32'(w_addr_ldr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word load, immediate gnt, rvalid two cycles later
    do_op(1, 0, 32'h40, 32'h0, 4'd3, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 11'h010, 4'h0, 32'h0);
    // Byte store to lane 3, gnt after three held cycles
    do_op(0, 1, 32'h103, 32'h123456AB, 4'd0, 3, 0, 32'h0, 32'h0, 11'h040, 4'b1000, 32'hABABABAB);
    // Byte load lane 2
    do_op(1, 1, 32'h22, 32'h0, 4'd7, 1, 1, 32'h11C37F00, 32'h000000C3, 11'h008, 4'h0, 32'h0);

    // Misaligned word load: no strobe, one-cycle align_err, stays ready
    m_active = 1'b0;
    is_load = 1'b1; is_byte = 1'b0; addr = 32'h42; rd_addr = 4'd5; req_valid = 1'b1;
    #1;
    chk("misalign_stall", 32'(stall), 1);
    @(negedge clk);
    chk("misalign_err", 32'(align_err), 1);
    chk("misalign_no_rd", 32'(mem_rd), 0);
    chk("misalign_ready", 32'(req_ready), 1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("misalign_err_pulse", 32'(align_err), 0);
    chk("misalign_no_rd2", 32'(mem_rd), 0);
    chk("misalign_ready2", 32'(req_ready), 1);

    // Reset while waiting for read data
    m_load = 1'b1; m_byte = 1'b0; m_addr = 32'h80; m_data = 32'h0; m_rd = 4'd9; m_active = 1'b1;
    is_load = 1'b1; is_byte = 1'b0; addr = 32'h80; rd_addr = 4'd9; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_rd", 32'(mem_rd), 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw_wait_stall", 32'(stall), 1);
    chk("rstw_wait_rd", 32'(mem_rd), 0);
    rst = 1'b1;
    m_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ready", 32'(req_ready), 1);
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_w_en", 32'(w_en_ldr), 0);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("rstw_late_rvalid", 32'(w_en_ldr), 0);
    chk("rstw_idle_stall", 32'(stall), 0);
    @(negedge clk);
    chk("rstw_late_rvalid2", 32'(w_en_ldr), 0);
    chk("rstw_ready2", 32'(req_ready), 1);

    // Zero-wait RAM then back-to-back ops
    do_op(1, 0, 32'h7FC, 32'h0, 4'd15, 0, 0, 32'h0BADF00D, 32'h0BADF00D, 11'h1FF, 4'h0, 32'h0);
    do_op(0, 0, 32'h1FFC, 32'hCAFEF00D, 4'd0, 0, 0, 32'h0, 32'h0, 11'h7FF, 4'b1111, 32'hCAFEF00D);
    do_op(1, 1, 32'h1, 32'h0, 4'd1, 0, 0, 32'h89ABCDEF, 32'h000000CD, 11'h000, 4'h0, 32'h0);
    do_op(0, 1, 32'h4, 32'h00000055, 4'd0, 2, 0, 32'h0, 32'h0, 11'h001, 4'b0001, 32'h55555555);

    repeat (3) @(negedge clk);
    chk("wb_count", wb_seen, exp_wb);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high; ports are clk and rst.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port: req_valid  in  1  memory op offered by execute stage.
REQ-005 SHALL have port: req_ready  out  1  unit can accept an op this cycle.
REQ-006 SHALL have port: is_load  in  1  op is load; 0 = store.
REQ-007 SHALL have port: is_byte  in  1  byte access (LDRB/STRB); 0 = word.
REQ-008 SHALL have port: addr  in  32  byte address (datapath_out of execute).
REQ-009 SHALL have port: str_data  in  32  store data from register file.
REQ-010 SHALL have port: rd_addr  in  4  load destination register.
REQ-011 SHALL have port: mem_addr  out  11  RAM word address = addr[12:2].
REQ-012 SHALL have port: mem_wdata  out  32 and mem_be  out  4  write data and byte enables.
REQ-013 SHALL have port: mem_rd, mem_wr  out  1 each  RAM strobes; mem_gnt  in  1  RAM accepted strobe.
REQ-014 SHALL have port: mem_rdata  in  32 and mem_rvalid  in  1  read data return.
REQ-015 SHALL have port: w_data_ldr  out  32, w_addr_ldr  out  4, w_en_ldr  out  1  load write-back to regfile.
REQ-016 SHALL have port: stall  out  1 and align_err  out  1  pipeline hold, one-cycle misalignment pulse.

Function
REQ-017 SHALL implement FSM IDLE -> REQ -> (WAIT if load) -> WB -> IDLE; stores go REQ -> IDLE.
REQ-018 SHALL assert req_ready only in IDLE; op accepted when req_valid & req_ready at clock edge.
REQ-019 SHALL latch addr, str_data, rd_addr, is_load, is_byte on acceptance; inputs ignored until return to IDLE.
REQ-020 SHALL drive mem_rd (load) or mem_wr (store) continuously in REQ until mem_gnt=1; never both.
REQ-021 SHALL, for word store, drive mem_be=4'b1111, mem_wdata=str_data.
REQ-022 SHALL, for byte store, replicate str_data[7:0] to all four lanes; mem_be one-hot at bit addr[1:0].
REQ-023 SHALL, in WAIT, hold until mem_rvalid=1, then capture mem_rdata and go to WB.
REQ-024 SHALL, for byte load, zero-extend lane addr[1:0] of captured word into w_data_ldr[7:0].
REQ-025 SHALL pulse w_en_ldr exactly one cycle in WB with w_addr_ldr=latched rd_addr; w_data_ldr held stable that cycle.
REQ-026 SHALL accept mem_rvalid in the same cycle as mem_gnt (REQ -> WB directly, zero-wait RAM).
REQ-027 SHALL assert stall whenever state != IDLE, and combinationally when req_valid in IDLE.
REQ-028 SHALL, on word access with addr[1:0]!=0, issue no memory strobe, pulse align_err one cycle, remain IDLE.
REQ-029 SHALL ignore mem_gnt/mem_rvalid outside REQ/WAIT.
REQ-030 SHALL give minimum latency acceptance-to-w_en_ldr of 2 cycles; store completes in 1 cycle after gnt.

Reset
REQ-031 SHALL, on rst, enter IDLE; outputs: req_ready=1, stall=0, mem_rd=mem_wr=0, mem_be=0, w_en_ldr=0, align_err=0, w_data_ldr=0, w_addr_ldr=0, mem_addr=0, mem_wdata=0.
REQ-032 SHALL, on rst mid-operation (any state), abandon op without write-back pulse; rst has priority over all inputs.

Verification
REQ-033 SHALL cover: word load addr=0x40, rd=3, gnt immediate, rvalid 2 cycles later data 0xDEADBEEF -> w_en_ldr 1 cycle, w_addr_ldr=3, w_data_ldr=0xDEADBEEF.
REQ-034 SHALL cover: byte store addr=0x103, str_data=0x123456AB -> mem_addr=0x040, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_wr held until gnt.
REQ-035 SHALL cover: byte load addr=0x22, mem_rdata=0x11C3_7F00 -> w_data_ldr=0x000000C3.
REQ-036 SHALL cover: word load addr=0x42 -> align_err pulse, no mem_rd, req_ready stays 1.
REQ-037 SHALL cover: rst asserted in WAIT, rvalid arrives after -> no w_en_ldr, state IDLE, stall=0.
REQ-038 SHALL cover: gnt and rvalid same cycle -> w_en_ldr next cycle; back-to-back ops accepted one cycle after WB.
